// File: rtl/antilog_converter_pipe.sv
// ---------------------------------------------------------------------------
// antilog_converter_pipe
// Multi-lane, two-stage pipelined antilog converter. Each lane turns a
// log-domain word {K, F, guard} into roughly 2^K * 1.F in the linear domain,
// with optional round-half-up on right shifts, saturation and two's-complement
// output. All lanes share a single valid/ready handshake and a saturating
// clamp-event counter.
//
// Ports
//   clk        : clock
//   rst        : synchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : input beat accepted this cycle (combinational)
//   in_log     : per-lane log words, lane i at [i*LW +: LW]
//   in_sign    : per-lane result sign (1 = negative)
//   in_zero    : per-lane zero flag, forces that lane's result to 0
//   out_valid  : output beat valid
//   out_ready  : downstream accepts the output beat
//   out_lin    : per-lane linear result, lane i at [i*OW +: OW]
//   out_sat    : per-lane clamp flag
//   sat_count  : total clamp events, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module antilog_converter_pipe #(
    parameter int unsigned DataIN_width     = 16,
    parameter int unsigned truncation_width = 6,
    parameter int unsigned bw_lg            = $clog2(DataIN_width),
    parameter int unsigned LANES            = 4,
    parameter bit          ROUND_EN         = 1'b1,
    parameter bit          SIGNED_OUT       = 1'b1,
    parameter bit          SAT_EN           = 1'b1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [LANES*(bw_lg+truncation_width+2)-1:0]           in_log,
    input  logic [LANES-1:0]                                      in_sign,
    input  logic [LANES-1:0]                                      in_zero,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [LANES*2*DataIN_width-1:0]                       out_lin,
    output logic [LANES-1:0]                                      out_sat,
    output logic [15:0]                                           sat_count
);

    localparam int unsigned TW    = truncation_width;
    localparam int unsigned KW    = bw_lg + 1;
    localparam int unsigned SW    = bw_lg + 2;
    localparam int unsigned LW    = bw_lg + TW + 2;
    localparam int unsigned OW    = 2 * DataIN_width;
    localparam int unsigned KMAX  = (1 << KW) - 1;
    // Largest left shift K - TW + 1 can request; the shifter is sized for it.
    localparam int unsigned MAXSH = (KMAX + 1 > TW) ? (KMAX + 1 - TW) : 0;
    localparam int unsigned MW    = TW + MAXSH;
    // Compare width: wide enough for the unclamped magnitude and the limit.
    localparam int unsigned CW    = ((MW > OW) ? MW : OW) + 1;
    localparam logic [CW-1:0] MAXV =
        (CW'(1) << (SIGNED_OUT ? (OW - 1) : OW)) - CW'(1);

    // Handshake: both stages move together whenever the output slot frees up.
    logic advance_c;
    assign advance_c = !out_valid || out_ready;
    assign in_ready  = advance_c;

    // -----------------------------------------------------------------------
    // Stage-1 state
    // -----------------------------------------------------------------------
    logic                s1_valid_q, s1_valid_d;
    logic [TW-1:0]       s1_xt_q   [LANES];
    logic [TW-1:0]       s1_xt_d   [LANES];
    logic                s1_neg_q  [LANES];
    logic                s1_neg_d  [LANES];
    logic [SW-1:0]       s1_amt_q  [LANES];
    logic [SW-1:0]       s1_amt_d  [LANES];
    logic [LANES-1:0]    s1_sign_q, s1_sign_d;
    logic [LANES-1:0]    s1_zero_q, s1_zero_d;

    // -----------------------------------------------------------------------
    // Stage-2 / output state
    // -----------------------------------------------------------------------
    logic                out_valid_q, out_valid_d;
    logic [LANES*OW-1:0] out_lin_q,   out_lin_d;
    logic [LANES-1:0]    out_sat_q,   out_sat_d;
    logic [15:0]         sat_count_q, sat_count_d;

    assign out_valid = out_valid_q;
    assign out_lin   = out_lin_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

    // Guard bits of each log word carry no information for this block.
    logic unused_guard_c;
    always_comb begin
        unused_guard_c = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            unused_guard_c = unused_guard_c ^ (^in_log[i*LW +: 2]);
        end
    end

    // Signed shift request K - (TW - 1) for one lane.
    function automatic logic [SW-1:0] calc_sub(input logic [KW-1:0] k);
        return SW'(k) - SW'(TW - 1);
    endfunction

    // Shift, round, clamp, negate and zero-force for one lane; returns {sat, value}.
    function automatic logic [OW:0] lane_convert(
        input logic [TW-1:0] xt,
        input logic          neg,
        input logic [SW-1:0] amt,
        input logic          sign,
        input logic          zero
    );
        logic [CW-1:0] mag;
        logic          rbit;
        logic [OW-1:0] res;
        logic          sat;
        mag  = '0;
        rbit = 1'b0;
        res  = '0;
        sat  = 1'b0;
        if (!neg) begin
            mag = CW'(xt) << amt;
        end else if (amt <= SW'(TW)) begin
            // Shifts past the mantissa width leave nothing, not even a round bit.
            mag = CW'(xt) >> amt;
            if (ROUND_EN) begin
                rbit = 1'((CW'(xt) >> (amt - SW'(1))));
                mag  = mag + CW'(rbit);
            end
        end
        if (mag > MAXV) begin
            if (SAT_EN) begin
                res = MAXV[OW-1:0];
                sat = 1'b1;
            end else begin
                res = mag[OW-1:0];
            end
        end else begin
            res = mag[OW-1:0];
        end
        if (SIGNED_OUT && sign) begin
            res = -res;
        end
        if (zero) begin
            res = '0;
            sat = 1'b0;
        end
        return {sat, res};
    endfunction

    // Adds this beat's clamp flags to the running count, sticking at all-ones.
    function automatic logic [15:0] sat_add(
        input logic [15:0]      cnt,
        input logic [LANES-1:0] flags
    );
        logic [16:0] sum;
        sum = {1'b0, cnt};
        for (int i = 0; i < LANES; i++) begin
            sum = sum + 17'(flags[i]);
        end
        if (sum > 17'h0FFFF) begin
            return 16'hFFFF;
        end
        return sum[15:0];
    endfunction

    // Stage-1 next state: field decode and shift direction/amount per lane.
    always_comb begin
        logic [KW-1:0] k;
        logic [SW-1:0] sub;
        k          = '0;
        sub        = '0;
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        for (int i = 0; i < LANES; i++) begin
            s1_xt_d[i]  = s1_xt_q[i];
            s1_neg_d[i] = s1_neg_q[i];
            s1_amt_d[i] = s1_amt_q[i];
        end
        if (advance_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_zero_d = in_zero;
                for (int i = 0; i < LANES; i++) begin
                    k           = in_log[i*LW + TW + 1 +: KW];
                    sub         = calc_sub(k);
                    s1_xt_d[i]  = {1'b1, in_log[i*LW + 2 +: TW-1]};
                    s1_neg_d[i] = sub[SW-1];
                    s1_amt_d[i] = sub[SW-1] ? (~sub + SW'(1)) : sub;
                end
            end
        end
    end

    // Stage-2 next state: conversion results and clamp accounting.
    always_comb begin
        logic [OW:0] conv;
        conv        = '0;
        out_valid_d = out_valid_q;
        out_lin_d   = out_lin_q;
        out_sat_d   = out_sat_q;
        sat_count_d = sat_count_q;
        if (advance_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                for (int i = 0; i < LANES; i++) begin
                    conv = lane_convert(s1_xt_q[i], s1_neg_q[i], s1_amt_q[i],
                                        s1_sign_q[i], s1_zero_q[i]);
                    out_lin_d[i*OW +: OW] = conv[OW-1:0];
                    out_sat_d[i]          = conv[OW];
                end
                // Counted once, as the beat lands in the output register.
                sat_count_d = sat_add(sat_count_q, out_sat_d);
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_lin_q   <= '0;
            out_sat_q   <= '0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_lin_q   <= out_lin_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    // Stage-1 payload registers; qualified by s1_valid_q, so no reset needed.
    always_ff @(posedge clk) begin
        s1_sign_q <= s1_sign_d;
        s1_zero_q <= s1_zero_d;
        for (int i = 0; i < LANES; i++) begin
            s1_xt_q[i]  <= s1_xt_d[i];
            s1_neg_q[i] <= s1_neg_d[i];
            s1_amt_q[i] <= s1_amt_d[i];
        end
    end

endmodule

// File: tb/tb_antilog_converter_pipe.sv
// Bench for antilog_converter_pipe: default parameters plus a ROUND_EN=0 twin.
module tb_antilog_converter_pipe;

    typedef struct packed {
        logic [127:0] lin;
        logic [3:0]   sat;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [47:0]  in_log;
    logic [3:0]   in_sign;
    logic [3:0]   in_zero;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_lin;
    logic [3:0]   out_sat;
    logic [15:0]  sat_count;

    logic         in_ready_nr;
    logic         out_valid_nr;
    logic [127:0] out_lin_nr;
    logic [3:0]   out_sat_nr;
    logic [15:0]  sat_count_nr;

    exp_t exp_q[$];
    exp_t got_q[$];
    exp_t got_nr_q[$];

    int          n_cmp;
    int          n_bad;
    int unsigned exp_sat_cnt;

    antilog_converter_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_log    (in_log),
        .in_sign   (in_sign),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lin   (out_lin),
        .out_sat   (out_sat),
        .sat_count (sat_count)
    );

    antilog_converter_pipe #(.ROUND_EN(1'b0)) dut_nr (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_nr),
        .in_log    (in_log),
        .in_sign   (in_sign),
        .in_zero   (in_zero),
        .out_valid (out_valid_nr),
        .out_ready (out_ready),
        .out_lin   (out_lin_nr),
        .out_sat   (out_sat_nr),
        .sat_count (sat_count_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] lin, input logic sat);
        return {96'd0, lin, 3'b000, sat};
    endfunction

    // Reference for lane 0: 2^K * 1.F with round-half-up, 31-bit clamp, sign.
    function automatic exp_t model(input logic [11:0] lg, input logic sg,
                                   input logic zr, input logic rnd);
        logic [4:0]      k;
        int              sub;
        longint unsigned xt;
        longint unsigned mag;
        logic [31:0]     lin;
        logic            s;
        k   = lg[11:7];
        sub = int'(k) - 5;
        xt  = 64'd32 + 64'(lg[6:2]);
        s   = 1'b0;
        if (sub >= 0) begin
            mag = xt << sub;
        end else begin
            mag = xt >> (-sub);
            if (rnd) mag = mag + ((xt >> (-sub - 1)) & 64'd1);
        end
        if (mag > 64'h7FFF_FFFF) begin
            mag = 64'h7FFF_FFFF;
            s   = 1'b1;
        end
        lin = mag[31:0];
        if (sg) lin = -lin;
        if (zr) begin
            lin = 32'd0;
            s   = 1'b0;
        end
        return mk(lin, s);
    endfunction

    // One cycle: drive lane 0 (other lanes zero-forced), record accepts and output transfers.
    task automatic drive_cycle(input logic v, input logic [11:0] lg, input logic sg,
                               input logic zr, input logic ordy, input exp_t e,
                               output logic acc, output logic rdy);
        in_valid  = v;
        in_log    = {36'd0, lg};
        in_sign   = {3'b000, sg};
        in_zero   = {3'b111, zr};
        out_ready = ordy;
        #1;
        rdy = in_ready;
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back(e);
            exp_sat_cnt = exp_sat_cnt + $countones(e.sat);
        end
        if (out_valid && out_ready)       got_q.push_back({out_lin, out_sat});
        if (out_valid_nr && out_ready)    got_nr_q.push_back({out_lin_nr, out_sat_nr});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a, r;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, '0, a, r);
    endtask

    task automatic send(input logic [11:0] lg, input logic sg, input logic zr, input exp_t e);
        logic a, r;
        drive_cycle(1'b1, lg, sg, zr, 1'b1, e, a, r);
        if (!a) begin
            n_cmp++; n_bad++;
            $display("FAIL send_accept: beat %h not accepted, in_ready=%b", lg, r);
        end
    endtask

    task automatic wait_out(input int n);
        int b;
        b = 0;
        while (got_q.size() < n && b < 20) begin
            idle(1);
            b++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_log = '0; in_sign = '0; in_zero = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_lin !== 128'd0)  begin n_bad++; $display("FAIL rst_out_lin: got %h want 0", out_lin); end
        n_cmp++; if (out_sat !== 4'd0)    begin n_bad++; $display("FAIL rst_out_sat: got %b want 0", out_sat); end
        n_cmp++; if (sat_count !== 16'd0) begin n_bad++; $display("FAIL rst_sat_count: got %0d want 0", sat_count); end
        n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        exp_sat_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        exp_t e, g;
        exp_q.delete(); got_q.delete();
        send(12'h380, 1'b0, 1'b0, mk(32'h0000_0080, 1'b0));
        idle(1);
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL lat_early: got %0d outputs want 0", got_q.size()); end
        idle(1);
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL lat_2cyc: got %0d outputs want 1", got_q.size()); end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g.lin !== e.lin) begin n_bad++; $display("FAIL k7_lin: got %h want %h", g.lin, e.lin); end
            n_cmp++; if (g.sat !== e.sat) begin n_bad++; $display("FAIL k7_sat: got %b want %b", g.sat, e.sat); end
        end
    endtask

    task automatic test_sign();
        exp_t e, g;
        exp_q.delete(); got_q.delete();
        send(12'h1C0, 1'b0, 1'b0, mk(32'd12, 1'b0));
        send(12'h1C0, 1'b1, 1'b0, mk(32'hFFFF_FFF4, 1'b0));
        wait_out(2);
        n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL sign_count: got %0d want 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL sign_val: got %h/%b want %h/%b", g.lin, g.sat, e.lin, e.sat); end
        end
    endtask

    task automatic test_round();
        exp_t e, g;
        exp_q.delete(); got_q.delete(); got_nr_q.delete();
        send(12'h040, 1'b0, 1'b0, mk(32'd2, 1'b0));
        wait_out(1);
        n_cmp++; if (got_q.size() !== 1 || got_nr_q.size() !== 1) begin
            n_bad++; $display("FAIL round_count: got %0d/%0d want 1/1", got_q.size(), got_nr_q.size());
        end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g.lin !== e.lin) begin n_bad++; $display("FAIL round_en1: got %h want %h", g.lin, e.lin); end
        end
        if (got_nr_q.size() > 0) begin
            g = got_nr_q.pop_front();
            n_cmp++; if (g.lin !== {96'd0, 32'd1}) begin n_bad++; $display("FAIL round_en0: got %h want 1", g.lin); end
        end
    endtask

    task automatic test_saturate();
        exp_t e, g;
        exp_q.delete(); got_q.delete();
        send(12'hF80, 1'b0, 1'b0, mk(32'h7FFF_FFFF, 1'b1));
        wait_out(1);
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL sat_count_out: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g.lin !== e.lin) begin n_bad++; $display("FAIL sat_lin: got %h want %h", g.lin, e.lin); end
            n_cmp++; if (g.sat !== e.sat) begin n_bad++; $display("FAIL sat_flag: got %b want %b", g.sat, e.sat); end
        end
        n_cmp++; if (sat_count !== 16'(exp_sat_cnt)) begin n_bad++; $display("FAIL sat_counter: got %0d want %0d", sat_count, exp_sat_cnt); end
        send(12'hF80, 1'b0, 1'b1, mk(32'd0, 1'b0));
        wait_out(1);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL zero_override: got %h/%b want %h/%b", g.lin, g.sat, e.lin, e.sat); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL zero_override: no output, want 1 beat");
        end
        n_cmp++; if (sat_count !== 16'd1) begin n_bad++; $display("FAIL zero_sat_counter: got %0d want 1", sat_count); end
    endtask

    task automatic test_back_to_back();
        logic [11:0]  lgs [5];
        logic         sgs [5];
        exp_t         e, g;
        logic         acc, rdy, ordy;
        logic [127:0] held;
        int           idx, j;
        lgs = '{12'h380, 12'h5FC, 12'hF80, 12'h2A4, 12'h0FC};
        sgs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_q.delete(); got_q.delete();
        idx = 0; j = 0; held = '0;
        while ((idx < 5 || got_q.size() < 5) && j < 40) begin
            ordy = !(j >= 2 && j <= 4);
            if (j == 2) held = out_lin;
            if (j >= 3 && j <= 5) begin
                n_cmp++;
                if (out_lin !== held || out_valid !== 1'b1) begin
                    n_bad++; $display("FAIL stall_hold: cycle %0d got %h v=%b want %h v=1", j, out_lin, out_valid, held);
                end
            end
            if (idx < 5) drive_cycle(1'b1, lgs[idx], sgs[idx], 1'b0, ordy, model(lgs[idx], sgs[idx], 1'b0, 1'b1), acc, rdy);
            else         drive_cycle(1'b0, 12'h000, 1'b0, 1'b0, ordy, '0, acc, rdy);
            if (j < 8) begin
                n_cmp++; if (rdy !== ordy) begin n_bad++; $display("FAIL stall_in_ready: cycle %0d got %b want %b", j, rdy, ordy); end
            end
            if (acc) idx++;
            j++;
        end
        n_cmp++; if (got_q.size() !== 5) begin n_bad++; $display("FAIL stream_count: got %0d want 5", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL stream_val: got %h/%b want %h/%b", g.lin, g.sat, e.lin, e.sat); end
        end
        n_cmp++; if (sat_count !== 16'(exp_sat_cnt)) begin n_bad++; $display("FAIL stream_sat_counter: got %0d want %0d", sat_count, exp_sat_cnt); end
    endtask

    task automatic test_reset_midstream();
        exp_t e, g;
        exp_q.delete(); got_q.delete();
        send(12'hF80, 1'b0, 1'b0, mk(32'h7FFF_FFFF, 1'b1));
        send(12'h380, 1'b0, 1'b0, mk(32'h0000_0080, 1'b0));
        n_cmp++; if (sat_count !== 16'(exp_sat_cnt)) begin n_bad++; $display("FAIL pre_rst_counter: got %0d want %0d", sat_count, exp_sat_cnt); end
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_cmp++; if (sat_count !== 16'd0) begin n_bad++; $display("FAIL midrst_counter: got %0d want 0", sat_count); end
        exp_q.delete(); got_q.delete(); exp_sat_cnt = 0;
        send(12'h1C0, 1'b0, 1'b0, mk(32'd12, 1'b0));
        idle(1);
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL post_rst_early: got %0d want 0", got_q.size()); end
        idle(1);
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL post_rst_lat: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL post_rst_val: got %h want %h", g.lin, e.lin); end
        end
        idle(2);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_drain: got valid %b want 0", out_valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_sat_cnt = 0;
        test_reset();
        test_latency();
        test_sign();
        test_round();
        test_saturate();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
